// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite single-outstanding master: turns a local command/response port
// into one AXI4-Lite read or write transaction at a time.
module axi_4_lite_mst #(
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                          RSP_VALID,
  output logic                          RSP_WRITE,
  output logic [C_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  output logic [15:0]                   DEB_WR_COUNT,
  output logic [15:0]                   DEB_RD_COUNT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;

  // State decode keeps the accept window exactly the IDLE cycles, including reset.
  assign CMD_READY    = (state == IDLE);
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_RREADY  <= 1'b0;
      RSP_VALID     <= 1'b0;
      RSP_WRITE     <= 1'b0;
      RSP_RDATA     <= '0;
      RSP_RESP      <= 2'b00;
      DEB_WR_COUNT  <= 16'd0;
      DEB_RD_COUNT  <= 16'd0;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            if (CMD_WRITE) begin
              M_AXI_AWADDR  <= CMD_ADDR;
              M_AXI_WDATA   <= CMD_WDATA;
              M_AXI_WSTRB   <= CMD_WSTRB;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_AW_W;
            end else begin
              M_AXI_ARADDR  <= CMD_ADDR;
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        // AW and W complete independently; move on once both have handshaken.
        WR_AW_W: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            M_AXI_BREADY <= 1'b0;
            RSP_RESP     <= M_AXI_BRESP;
            RSP_RDATA    <= '0;
            RSP_WRITE    <= 1'b1;
            RSP_VALID    <= 1'b1;
            state        <= DONE;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            M_AXI_RREADY <= 1'b0;
            RSP_RESP     <= M_AXI_RRESP;
            RSP_RDATA    <= M_AXI_RDATA;
            RSP_WRITE    <= 1'b0;
            RSP_VALID    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (RSP_WRITE) DEB_WR_COUNT <= DEB_WR_COUNT + 16'd1;
          else           DEB_RD_COUNT <= DEB_RD_COUNT + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
